// File: rtl/rx_fifo_credit.sv
// Receive-side N-char buffer with flow-control credit tracking.
// Decoded N-chars land in a first-word-fall-through FIFO. A small FSM asks
// the transmitter for FCTs while both the credit ceiling and the free buffer
// space can absorb another chunk. Credit misuse and overflow are flagged
// stickily, and EOP/EEP arrivals are pulsed one cycle after acceptance.
module rx_fifo_credit #(
  parameter int DEPTH      = 64,
  parameter int AW         = 6,
  parameter int MAX_CREDIT = 56,
  parameter int FCT_CHUNK  = 8
) (
  input  logic          posedge_clk,
  input  logic          rx_resetn,
  input  logic          link_running,
  input  logic [8:0]    rx_data_flag,
  input  logic          rx_buffer_write,
  input  logic          fct_sent,
  input  logic          rd_en,
  output logic [8:0]    rd_data,
  output logic          rd_valid,
  output logic          fifo_full,
  output logic [AW:0]   fifo_count,
  output logic [5:0]    credit_count,
  output logic          send_fct_req,
  output logic          credit_error,
  output logic          got_eop,
  output logic          got_eep
);

  typedef enum logic [1:0] {
    OFF,
    READY,
    REQ
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [AW:0]     count_q, count_d;
  logic [5:0]      credit_q, credit_d;
  logic            sendReq_q;
  logic            creditErr_q, creditErr_d;
  logic            gotEop_q, gotEep_q;
  logic [8:0]      mem_q [DEPTH];

  logic            active;
  logic            strobe;
  logic            rdAccept;
  logic            wrAccept;
  logic            overflow;
  logic            zeroCredit;
  logic            canRequest;
  logic [31:0]     creditWide;
  logic [31:0]     freeWide;

  // The link must be running and the FSM out of OFF before anything is accepted.
  assign active     = link_running && (state_q != OFF);
  assign strobe     = rx_buffer_write && active;
  assign rdAccept   = rd_en && (count_q != '0);
  assign wrAccept   = strobe && (!fifo_full || rd_en);
  assign overflow   = strobe && fifo_full && !rd_en;
  assign zeroCredit = strobe && (credit_q == '0);

  // Another FCT fits if both the credit ceiling and the free space allow a whole chunk.
  assign creditWide = 32'(credit_q) + 32'(FCT_CHUNK);
  assign freeWide   = 32'(DEPTH) - 32'(count_q);
  assign canRequest = (creditWide <= 32'(MAX_CREDIT)) && (freeWide >= creditWide);

  // Next pointer and occupancy; an inactive link flushes the buffer back to empty.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (!active) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wrAccept) wrPtr_d = wrPtr_q + 1'b1;
      if (rdAccept) rdPtr_d = rdPtr_q + 1'b1;
      count_d = count_q + (AW+1)'(wrAccept) - (AW+1)'(rdAccept);
    end
  end

  // Next credit: one per strobe while credit remains, plus a chunk when an FCT goes out.
  always_comb begin
    credit_d = credit_q;
    if (strobe && (credit_q != '0)) credit_d = credit_q - 6'd1;
    if ((state_q == REQ) && fct_sent) credit_d = credit_d + 6'(FCT_CHUNK);
    if (32'(credit_d) > 32'(MAX_CREDIT)) credit_d = 6'(MAX_CREDIT);
    creditErr_d = creditErr_q || zeroCredit || overflow;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge posedge_clk) begin
    if (wrAccept) mem_q[wrPtr_q] <= rx_data_flag;
  end

  // Credit FSM with registered request, credit and sticky error.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      state_q     <= OFF;
      credit_q    <= '0;
      sendReq_q   <= 1'b0;
      creditErr_q <= 1'b0;
    end else if (!link_running) begin
      state_q     <= OFF;
      credit_q    <= '0;
      sendReq_q   <= 1'b0;
      creditErr_q <= 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          state_q     <= READY;
          credit_q    <= '0;
          sendReq_q   <= 1'b0;
          creditErr_q <= 1'b0;
        end
        READY: begin
          credit_q    <= credit_d;
          creditErr_q <= creditErr_d;
          if (canRequest) begin
            state_q   <= REQ;
            sendReq_q <= 1'b1;
          end
        end
        REQ: begin
          credit_q    <= credit_d;
          creditErr_q <= creditErr_d;
          if (fct_sent) begin
            state_q   <= READY;
            sendReq_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= OFF;
          sendReq_q <= 1'b0;
        end
      endcase
    end
  end

  // End-of-packet markers pulse the cycle after the marker is accepted.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      gotEop_q <= 1'b0;
      gotEep_q <= 1'b0;
    end else begin
      gotEop_q <= wrAccept && (rx_data_flag == 9'h100);
      gotEep_q <= wrAccept && (rx_data_flag == 9'h101);
    end
  end

  assign rd_valid     = (count_q != '0);
  assign rd_data      = rd_valid ? mem_q[rdPtr_q] : 9'h000;
  assign fifo_full    = (count_q == (AW+1)'(DEPTH));
  assign fifo_count   = count_q;
  assign credit_count = credit_q;
  assign send_fct_req = sendReq_q;
  assign credit_error = creditErr_q;
  assign got_eop      = gotEop_q;
  assign got_eep      = gotEep_q;

endmodule

// File: tb/tb_rx_fifo_credit.sv
// Bench for rx_fifo_credit: a queue-based reference model is compared with
// the DUT every cycle, and directed scenarios pin key values by hand.
module tb_rx_fifo_credit;

  localparam int DEPTH = 64;
  localparam int MAXC  = 56;
  localparam int CHUNK = 8;

  logic        posedge_clk = 1'b0;
  logic        rx_resetn = 1'b0;
  logic        link_running = 1'b0;
  logic [8:0]  rx_data_flag = 9'h000;
  logic        rx_buffer_write = 1'b0;
  logic        fct_sent = 1'b0;
  logic        rd_en = 1'b0;
  logic [8:0]  rd_data;
  logic        rd_valid;
  logic        fifo_full;
  logic [6:0]  fifo_count;
  logic [5:0]  credit_count;
  logic        send_fct_req;
  logic        credit_error;
  logic        got_eop;
  logic        got_eep;

  int totalChecks = 0;
  int badChecks = 0;

  rx_fifo_credit dut (
    .posedge_clk     (posedge_clk),
    .rx_resetn       (rx_resetn),
    .link_running    (link_running),
    .rx_data_flag    (rx_data_flag),
    .rx_buffer_write (rx_buffer_write),
    .fct_sent        (fct_sent),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .fifo_full       (fifo_full),
    .fifo_count      (fifo_count),
    .credit_count    (credit_count),
    .send_fct_req    (send_fct_req),
    .credit_error    (credit_error),
    .got_eop         (got_eop),
    .got_eep         (got_eep)
  );

  always #5 posedge_clk = ~posedge_clk;

  // Reference model state: buffered chars, credit, request, error, markers.
  logic [8:0] mQ[$];
  int  mCredit = 0;
  bit  mReq = 1'b0;
  bit  mErr = 1'b0;
  bit  mUp = 1'b0;
  bit  mEop = 1'b0;
  bit  mEep = 1'b0;
  int  oldCredit;
  int  oldSize;
  bit  doPop;
  bit  doPush;

  // Advance the reference model on each clock edge, or clear it on reset.
  always @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn || !link_running) begin
      mQ.delete();
      mCredit = 0;
      mReq = 1'b0;
      mErr = 1'b0;
      mUp = 1'b0;
      mEop = 1'b0;
      mEep = 1'b0;
    end else if (!mUp) begin
      mUp = 1'b1;
      mEop = 1'b0;
      mEep = 1'b0;
    end else begin
      oldCredit = mCredit;
      oldSize = mQ.size();
      doPop = rd_en && (oldSize > 0);
      doPush = rx_buffer_write && ((oldSize < DEPTH) || rd_en);
      if (rx_buffer_write && (oldCredit == 0)) mErr = 1'b1;
      if (rx_buffer_write && (oldSize == DEPTH) && !rd_en) mErr = 1'b1;
      if (rx_buffer_write && (oldCredit > 0)) mCredit = mCredit - 1;
      if (mReq) begin
        if (fct_sent) begin
          mCredit = mCredit + CHUNK;
          mReq = 1'b0;
        end
      end else if ((oldCredit + CHUNK <= MAXC) && (DEPTH - oldSize >= oldCredit + CHUNK)) begin
        mReq = 1'b1;
      end
      if (mCredit > MAXC) mCredit = MAXC;
      mEop = doPush && (rx_data_flag == 9'h100);
      mEep = doPush && (rx_data_flag == 9'h101);
      if (doPop) void'(mQ.pop_front());
      if (doPush) mQ.push_back(rx_data_flag);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output with the model midway between clock edges.
  always @(negedge posedge_clk) begin
    checkOutput("cyc_count", int'(fifo_count), mQ.size());
    checkOutput("cyc_valid", int'(rd_valid), int'(mQ.size() > 0));
    checkOutput("cyc_full", int'(fifo_full), int'(mQ.size() == DEPTH));
    checkOutput("cyc_data", int'(rd_data), (mQ.size() > 0) ? int'(mQ[0]) : 0);
    checkOutput("cyc_credit", int'(credit_count), mCredit);
    checkOutput("cyc_req", int'(send_fct_req), int'(mReq));
    checkOutput("cyc_err", int'(credit_error), int'(mErr));
    checkOutput("cyc_eop", int'(got_eop), int'(mEop));
    checkOutput("cyc_eep", int'(got_eep), int'(mEep));
  end

  task automatic applyStimulus(input bit wr, input logic [8:0] d, input bit fct, input bit rd);
    rx_buffer_write = wr;
    rx_data_flag = d;
    fct_sent = fct;
    rd_en = rd;
    @(posedge posedge_clk);
    #1;
    rx_buffer_write = 1'b0;
    rx_data_flag = 9'h000;
    fct_sent = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
  endtask

  task automatic grantFct();
    int waited;
    waited = 0;
    while (!mReq && (waited < 10)) begin
      applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
      waited++;
    end
    checkOutput("grant_wait", int'(mReq), 1);
    applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle(3);
    checkOutput("rst_count", int'(fifo_count), 0);
    checkOutput("rst_credit", int'(credit_count), 0);
    checkOutput("rst_valid", int'(rd_valid), 0);
    checkOutput("rst_req", int'(send_fct_req), 0);
    checkOutput("rst_data", int'(rd_data), 0);

    // Scenario 1: link up, request after two cycles, seven grants to the ceiling.
    rx_resetn = 1'b1;
    link_running = 1'b1;
    idle(1);
    checkOutput("s1_req_c1", int'(send_fct_req), 0);
    idle(1);
    checkOutput("s1_req_c2", int'(send_fct_req), 1);
    for (int g = 0; g < 7; g++) grantFct();
    idle(3);
    checkOutput("s1_credit56", int'(credit_count), 56);
    checkOutput("s1_noreq", int'(send_fct_req), 0);

    // Scenario 2: spend all credit, then free space to earn a new request.
    for (int i = 0; i < 56; i++) applyStimulus(1'b1, 9'(i), 1'b0, 1'b0);
    checkOutput("s2_count56", int'(fifo_count), 56);
    checkOutput("s2_credit0", int'(credit_count), 0);
    checkOutput("s2_req", int'(send_fct_req), 1);
    grantFct();
    idle(2);
    checkOutput("s2_credit8", int'(credit_count), 8);
    checkOutput("s2_noreq", int'(send_fct_req), 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);
    idle(2);
    checkOutput("s2_count48", int'(fifo_count), 48);
    checkOutput("s2_newreq", int'(send_fct_req), 1);
    grantFct();

    // Scenario 3: fill, then zero-credit write, full read+write, full drop.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 9'(64 + i), 1'b0, 1'b0);
    checkOutput("s3_full", int'(fifo_full), 1);
    checkOutput("s3_noerr", int'(credit_error), 0);
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);
    applyStimulus(1'b1, 9'h0AA, 1'b0, 1'b0);
    checkOutput("s3_err", int'(credit_error), 1);
    checkOutput("s3_stored", int'(fifo_count), 64);
    applyStimulus(1'b1, 9'h0BB, 1'b0, 1'b1);
    checkOutput("s3_rdwr_full", int'(fifo_count), 64);
    applyStimulus(1'b1, 9'h0CC, 1'b0, 1'b0);
    checkOutput("s3_drop", int'(fifo_count), 64);
    for (int i = 0; i < 64; i++) applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);
    checkOutput("s3_empty", int'(fifo_count), 0);
    checkOutput("s3_sticky", int'(credit_error), 1);
    link_running = 1'b0;
    idle(1);
    checkOutput("s3_off_count", int'(fifo_count), 0);
    checkOutput("s3_off_err", int'(credit_error), 0);
    checkOutput("s3_off_credit", int'(credit_count), 0);

    // Scenario 4: grant coinciding with a write at credit 10.
    link_running = 1'b1;
    grantFct();
    grantFct();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 9'(8'h11 + i), 1'b0, 1'b0);
    checkOutput("s4_credit10", int'(credit_count), 10);
    checkOutput("s4_reqheld", int'(send_fct_req), 1);
    applyStimulus(1'b1, 9'h0EE, 1'b1, 1'b0);
    checkOutput("s4_credit17", int'(credit_count), 17);

    // Scenario 5: EOP then EEP markers and their order in the buffer.
    applyStimulus(1'b1, 9'h100, 1'b0, 1'b0);
    checkOutput("s5_eop", int'(got_eop), 1);
    checkOutput("s5_eop_eep", int'(got_eep), 0);
    applyStimulus(1'b1, 9'h101, 1'b0, 1'b0);
    checkOutput("s5_eep_eop", int'(got_eop), 0);
    checkOutput("s5_eep", int'(got_eep), 1);
    idle(1);
    checkOutput("s5_quiet", int'(got_eop) + int'(got_eep), 0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);
    checkOutput("s5_head100", int'(rd_data), 256);
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);
    checkOutput("s5_head101", int'(rd_data), 257);
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);

    // Scenario 6: asynchronous reset with data buffered and a request pending.
    grantFct();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 9'(i + 1), 1'b0, 1'b0);
    checkOutput("s6_count20", int'(fifo_count), 20);
    checkOutput("s6_reqpend", int'(send_fct_req), 1);
    #2;
    rx_resetn = 1'b0;
    #1;
    checkOutput("s6_count0", int'(fifo_count), 0);
    checkOutput("s6_credit0", int'(credit_count), 0);
    checkOutput("s6_req0", int'(send_fct_req), 0);
    checkOutput("s6_valid0", int'(rd_valid), 0);
    checkOutput("s6_data0", int'(rd_data), 0);
    checkOutput("s6_full0", int'(fifo_full), 0);
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);
    rx_resetn = 1'b1;
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);
    checkOutput("s6_underflow", int'(fifo_count), 0);
    checkOutput("s6_uf_valid", int'(rd_valid), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
